// File: rtl/lowmask_share_arb.sv
// Round-robin arbiter sharing one low-mask generator among NUM_REQ requesters.
// The winner's mask is captured in a single output register with valid/ready.
module lowmask_share_arb #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IN_W     = 6,
  parameter int unsigned OUT_W    = 24,
  parameter int unsigned LO_BOUND = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*IN_W-1:0]    req_amount,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [OUT_W-1:0]           resp_mask
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [IN_W-1:0]  amt_arr [NUM_REQ];
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic [IN_W-1:0]  gnt_amt;
  logic [OUT_W-1:0] gnt_mask;
  logic             gnt_any;
  logic             gnt_fire;
  logic             slot_free;
  int unsigned      idx;
  int               d;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign amt_arr[k] = req_amount[k*IN_W +: IN_W];
  end

  // First valid requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    gnt_amt   = '0;
    idx       = 0;
    req_ready = '0;
    slot_free = !resp_valid || resp_ready;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_REQ;
      if (!gnt_any && req_valid[ID_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
        gnt_amt = amt_arr[ID_W'(idx)];
      end
    end
    gnt_fire = slot_free && gnt_any && !reset;
    if (gnt_fire) req_ready[gnt_idx] = 1'b1;
  end

  // Mask: the d LSBs set, with d = amount - LO_BOUND on zero-extended amounts.
  always_comb begin
    gnt_mask = '0;
    d = $signed(32'(gnt_amt)) - $signed(32'(LO_BOUND));
    for (int i = 0; i < int'(OUT_W); i++) begin
      gnt_mask[i] = (i < d);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_mask  <= '0;
      rr_ptr     <= '0;
    end else if (gnt_fire) begin
      resp_valid <= 1'b1;
      resp_id    <= gnt_idx;
      resp_mask  <= gnt_mask;
      rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lowmask_share_arb.sv
// Bench for lowmask_share_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_lowmask_share_arb;

  localparam int N     = 4;
  localparam int IN_W  = 6;
  localparam int OUT_W = 24;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*IN_W-1:0] req_amount = '0;
  logic [N-1:0]     req_ready;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [1:0]       resp_id;
  logic [OUT_W-1:0] resp_mask;

  // Second instance with a non-zero lower bound.
  logic [N-1:0]      lo_valid = '0;
  logic [N*IN_W-1:0] lo_amount = '0;
  logic [N-1:0]      lo_req_ready;
  logic              lo_resp_valid;
  logic [1:0]        lo_resp_id;
  logic [OUT_W-1:0]  lo_resp_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  lowmask_share_arb #(.NUM_REQ(N), .IN_W(IN_W), .OUT_W(OUT_W), .LO_BOUND(0)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_mask(resp_mask));

  lowmask_share_arb #(.NUM_REQ(N), .IN_W(IN_W), .OUT_W(OUT_W), .LO_BOUND(3)) dut_lo (
    .clock(clock), .reset(reset), .req_valid(lo_valid), .req_amount(lo_amount),
    .req_ready(lo_req_ready), .resp_valid(lo_resp_valid), .resp_ready(1'b1),
    .resp_id(lo_resp_id), .resp_mask(lo_resp_mask));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_mask(input int amt, input int lo);
    int dd;
    dd = amt - lo;
    if (dd <= 0) return '0;
    if (dd >= OUT_W) return '1;
    return OUT_W'((64'd1 << dd) - 64'd1);
  endfunction

  function automatic int amt_of(input int k);
    logic [N*IN_W-1:0] v;
    v = req_amount;
    return int'(v[k*IN_W +: IN_W]);
  endfunction

  // Behavioural model: one output slot, a pointer, and a first-at-or-after search.
  bit           m_live = 0;
  bit           m_valid;
  int           m_id;
  logic [OUT_W-1:0] m_mask;
  int           m_ptr;

  always @(negedge clock) begin
    int win;
    logic [N-1:0] exp_ready;
    win = -1;
    if (!reset && (!m_valid || resp_ready)) begin
      for (int s = 0; s < N; s++) begin
        if (win < 0 && req_valid[(m_ptr + s) % N]) win = (m_ptr + s) % N;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    if (m_live) begin
      check("model_req_ready", 64'(req_ready), 64'(exp_ready));
      check("model_resp_valid", 64'(resp_valid), 64'(m_valid));
      if (m_valid) begin
        check("model_resp_id", 64'(resp_id), 64'(m_id));
        check("model_resp_mask", 64'(resp_mask), 64'(m_mask));
      end
    end
    if (reset) begin
      m_live = 1; m_valid = 0; m_id = 0; m_mask = '0; m_ptr = 0;
    end else if (win >= 0) begin
      m_valid = 1; m_id = win; m_mask = ref_mask(amt_of(win), 0); m_ptr = (win + 1) % N;
    end else if (resp_ready) begin
      m_valid = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_amt(input int k, input int a);
    req_amount[k*IN_W +: IN_W] = IN_W'(a);
  endtask

  int amts   [6] = '{0, 1, 5, 23, 24, 63};
  int masks  [6] = '{'h000000, 'h000001, 'h00001F, 'h7FFFFF, 'hFFFFFF, 'hFFFFFF};
  int lo_amts[3] = '{2, 3, 4};
  int lo_msks[3] = '{'h000000, 'h000000, 'h000001};
  logic [N-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    logic [OUT_W-1:0] held;
    logic [N-1:0] pend;
    logic [N-1:0] granted;
    tick();
    tick();
    reset = 1'b0;
    check("reset_valid", 64'(resp_valid), 64'd0);
    check("reset_id", 64'(resp_id), 64'd0);
    check("reset_mask", 64'(resp_mask), 64'd0);

    // Mask boundaries, requester 0 only.
    resp_ready = 1'b1;
    req_valid = 4'b0001;
    lo_valid = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      set_amt(0, amts[i]);
      if (i < 3) lo_amount[IN_W-1:0] = IN_W'(lo_amts[i]);
      tick();
      check("mask_boundary", 64'(resp_mask), 64'(masks[i]));
      if (i < 3) check("mask_lo_bound", 64'(lo_resp_mask), 64'(lo_msks[i]));
    end
    lo_valid = '0;

    // Round-robin with everyone valid.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(rr_seq[i]));
      tick();
      check("rr_id", 64'(resp_id), 64'(i % N));
    end

    // Backpressure with requesters 1 and 2.
    do_reset();
    set_amt(1, 9);
    set_amt(2, 30);
    req_valid = 4'b0110;
    resp_ready = 1'b0;
    #1;
    check("bp_first_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b0100;
    held = resp_mask;
    check("bp_first_mask", 64'(held), 64'h0001FF);
    for (int i = 0; i < 3; i++) begin
      check("bp_stall_ready", 64'(req_ready), 64'd0);
      check("bp_stall_id", 64'(resp_id), 64'd1);
      check("bp_stall_mask", 64'(resp_mask), 64'(held));
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    check("bp_no_bubble", 64'(resp_valid), 64'd1);
    check("bp_second_id", 64'(resp_id), 64'd2);

    // Sparse single request from requester 3.
    do_reset();
    set_amt(3, 2);
    req_valid = 4'b1000;
    #1;
    check("sparse_grant", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    check("sparse_valid", 64'(resp_valid), 64'd1);
    check("sparse_id", 64'(resp_id), 64'd3);
    tick();
    check("sparse_drop", 64'(resp_valid), 64'd0);
    req_valid = 4'b1001;
    #1;
    check("sparse_wrap", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;

    // Reset during a stall.
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("rst_ready_low", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    check("rst_stall_valid", 64'(resp_valid), 64'd0);
    check("rst_stall_id", 64'(resp_id), 64'd0);
    check("rst_stall_mask", 64'(resp_mask), 64'd0);
    resp_ready = 1'b1;
    #1;
    check("rst_first_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;

    // Random traffic honouring the hold-until-granted contract.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      granted = req_ready & req_valid;
      @(posedge clock);
      #1;
      pend &= ~granted;
      if (reset) pend = '0;
      reset = ($urandom_range(0, 199) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          set_amt(k, $urandom_range(0, 63));
        end
      end
      req_valid = pend;
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lowmask_share_arb.md
Name: lowmask_share_arb

Overview:
- Shares one low-mask generator among NUM_REQ requesters. Typical requesters are rounding and normalization stages of several FP pipes.
- A round-robin arbiter picks one pending request per cycle. It computes the mask and holds the result in a single output register, with valid/ready handshake on both sides.
- Sits between the per-pipe rounding control and the shared mask resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IN_W, 6, width of each shift/exponent amount.
- OUT_W, 24, mask width.
- LO_BOUND, 0, amount value that maps to an all-zero mask.

Ports:
- clock  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_amount  input  NUM_REQ*IN_W  flattened amounts; requester k uses bits [k*IN_W +: IN_W].
- req_ready  output  NUM_REQ  one-hot grant; the handshake completes when req_valid[k] and req_ready[k] are both high.
- resp_valid  output  1  output register holds a result.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  clog2(NUM_REQ)  index of the requester that owns the result.
- resp_mask  output  OUT_W  computed mask.

Behaviour:
- Mask function: let d = amount − LO_BOUND, evaluated as a signed (IN_W+1)-bit value.
  - d ≤ 0 → mask = 0.
  - d ≥ OUT_W → mask = all ones.
  - Otherwise mask bit i = 1 iff i < d, i.e. the d LSBs are set.
  - Purely combinational from the granted amount; registered into resp_mask.
- Output slot is free when resp_valid = 0, or when resp_valid = 1 and resp_ready = 1 in the same cycle. Full throughput is kept under continuous resp_ready.
- Arbitration, evaluated each cycle:
  - If the slot is free and any req_valid is high, grant the first valid requester at or after rr_ptr, searching upward with wrap.
  - req_ready is asserted combinationally for that one requester only.
  - When the slot is not free, req_ready = 0 for everyone.
  - req_ready never asserts for a requester whose req_valid is low.
- On a grant at edge t:
  - resp_valid = 1, resp_id = k and resp_mask = f(amount_k) from edge t+1.
  - Latency is exactly 1 cycle.
  - rr_ptr ← (k+1) mod NUM_REQ.
- Hold and clear:
  - While resp_valid = 1 and resp_ready = 0, resp_id and resp_mask hold stable.
  - If the slot is consumed with no new grant, resp_valid → 0. resp_mask and resp_id keep their last values and are don't-care.
- rr_ptr changes only on a grant.
- Requester contract: a requester keeps req_valid and req_amount stable until it is granted. The block does not check this.
- Fairness: with all requesters continuously valid and resp_ready = 1, grants go 0,1,…,NUM_REQ−1,0,… Each requester waits at most NUM_REQ−1 grants.
- Reset, applied at any time including mid-transfer:
  - Next edge: resp_valid = 0, resp_id = 0, resp_mask = 0, rr_ptr = 0.
  - A pending result is dropped.
  - req_ready = 0 during the reset cycle.
- Simultaneous events: a consume and a new grant in the same cycle replace the result in place; resp_valid stays 1.
- Amounts with the MSB set are unsigned. d is computed on zero-extended amounts, so there is no wrap-around to negative.

Test Plan:
- Reset mid-stall: hold resp_valid = 1 and resp_ready = 0, pulse reset → next cycle resp_valid = 0, resp_id = 0, resp_mask = 0. The first later grant goes to requester 0 when all are valid.
- Mask boundaries (NUM_REQ = 4, OUT_W = 24, LO_BOUND = 0), requester 0 only, resp_ready = 1:
  - amount 0 → 0x000000
  - amount 1 → 0x000001
  - amount 5 → 0x00001F
  - amount 23 → 0x7FFFFF
  - amount 24 → 0xFFFFFF
  - amount 63 → 0xFFFFFF
- LO_BOUND = 3:
  - amount 2 → 0x000000
  - amount 3 → 0x000000
  - amount 4 → 0x000001
- Round-robin: all 4 requesters valid continuously, resp_ready = 1 → req_ready sequence 0001, 0010, 0100, 1000, 0001. resp_id follows one cycle later: 0,1,2,3,0.
- Backpressure: requesters 1 and 2 valid, resp_ready = 0 for 3 cycles after the first grant → resp_id = 1 and its mask held stable. req_ready = 0000 throughout. On resp_ready = 1: same-cycle grant to requester 2, and resp_valid stays 1 with no bubble.
- Sparse requests: only requester 3 valid once, then idle → req_ready = 1000 for one cycle. resp_valid high for exactly one cycle with resp_ready = 1, then 0. rr_ptr = 0, so the next simultaneous request from 0 and 3 grants 0.
